// File: rtl/exec_hazard_ctrl.sv
// Execute-stage pipeline controller: load-use stall, ALU operand forwarding,
// multi-cycle MUL/DIV/FP sequencing and redirect squash.
module exec_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int FP_LAT  = 6,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_rw,
    input  logic       ex_regwr,
    input  logic       ex_load,
    input  logic       ex_start_mc,
    input  logic [1:0] ex_mc_type,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwr,
    input  logic [4:0] wb_rw,
    input  logic       wb_regwr,
    input  logic       redirect,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       ex_hold,
    output logic       exmem_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mc_busy,
    output logic       mc_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter preload is LAT-2: the start cycle and the DONE cycle are not counted.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] FP_LOAD  = CNT_W'(FP_LAT - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] lat_load;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rw,
        input logic       m_wr,
        input logic [4:0] w_rw,
        input logic       w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_wr && (m_rw != 5'd0) && (m_rw == src)) begin
            sel = 2'b10;
        end else if (w_wr && (w_rw != 5'd0) && (w_rw == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        case (ex_mc_type)
            2'b01:   lat_load = DIV_LOAD;
            2'b10:   lat_load = FP_LOAD;
            default: lat_load = MUL_LOAD;
        endcase
    end

    assign load_use = ex_load && ex_regwr && (ex_rw != 5'd0) && id_valid &&
                      ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seen_d       = 1'b1;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;
        // Everything stays quiet until one clean clock has passed after reset.
        if (seen_q) begin
            fwd_a = fwd_sel(ex_rs, mem_rw, mem_regwr, wb_rw, wb_regwr);
            fwd_b = fwd_sel(ex_rt, mem_rw, mem_regwr, wb_rw, wb_regwr);
            case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        // EX holds a younger, squashed instruction: never start it.
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = ex_start_mc;
                    end else if (ex_start_mc) begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        ex_hold      = 1'b1;
                        exmem_bubble = 1'b1;
                        mc_busy      = 1'b1;
                        cnt_d        = lat_load;
                        state_d      = (lat_load == '0) ? S_DONE : S_RUN;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                S_RUN: begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    mc_busy      = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    mc_busy = 1'b1;
                    mc_done = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Bench for exec_hazard_ctrl: vector table, hand-built multi-cycle sequences,
// and random traffic against an occupancy-position reference model.
module tb_exec_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
    localparam int FP_LAT  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, ex_regwr, ex_load, ex_start_mc;
    logic       mem_regwr, wb_regwr, redirect;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
    logic [1:0] ex_mc_type;
    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, exmem_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic       mc_busy, mc_done;

    always #5 clk = ~clk;

    exec_hazard_ctrl #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FP_LAT(FP_LAT), .CNT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr),
        .ex_load(ex_load), .ex_start_mc(ex_start_mc), .ex_mc_type(ex_mc_type),
        .mem_rw(mem_rw), .mem_regwr(mem_regwr), .wb_rw(wb_rw), .wb_regwr(wb_regwr),
        .redirect(redirect),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .ex_hold(ex_hold), .exmem_bubble(exmem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, exmem_bubble, fwd_a, fwd_b, mc_busy, mc_done}
    wire [11:0] dut_out = {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold,
                           exmem_bubble, fwd_a, fwd_b, mc_busy, mc_done};

    localparam logic [11:0] O_BUSY = 12'b1100_1100_0010;
    localparam logic [11:0] O_DONE = 12'b0000_0000_0011;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rw;
        logic       ex_regwr;
        logic       ex_load;
        logic       ex_start_mc;
        logic [1:0] ex_mc_type;
        logic [4:0] mem_rw;
        logic       mem_regwr;
        logic [4:0] wb_rw;
        logic       wb_regwr;
        logic       redirect;
    } in_t;

    typedef struct {
        in_t         in;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: m_pos is the 1-based cycle index inside a multi-cycle
    // op (0 = no op in flight); the op occupies EX for m_lat cycles.
    bit m_seen = 1'b0;
    int m_pos  = 0;
    int m_lat  = 0;

    function automatic int lat_of(input logic [1:0] t);
        if (t == 2'b01) return DIV_LAT;
        if (t == 2'b10) return FP_LAT;
        return MUL_LAT;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r != 0 && mem_regwr && mem_rw == r) return 2'b10;
        if (r != 0 && wb_regwr && wb_rw == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out();
        logic       hz;
        logic [5:0] ctl;
        logic [1:0] st;
        if (!m_seen) return 12'd0;
        hz = ex_load && ex_regwr && ex_rw != 0 && id_valid &&
             (ex_rw == id_rs || (id_uses_rt && ex_rw == id_rt));
        ctl = 6'b0;
        st  = 2'b0;
        if (m_pos == 0) begin
            if (redirect)         ctl = {4'b0011, 1'b0, ex_start_mc};
            else if (ex_start_mc) begin ctl = 6'b110011; st = 2'b10; end
            else if (hz)          ctl = 6'b110100;
        end else if (m_pos < m_lat) begin
            ctl = 6'b110011; st = 2'b10;
        end else begin
            st = 2'b11;
        end
        return {ctl, m_fwd(ex_rs), m_fwd(ex_rt), st};
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_seen = 1'b0;
            m_pos  = 0;
        end else if (!m_seen) begin
            m_seen = 1'b1;
        end else if (m_pos == 0) begin
            if (ex_start_mc && !redirect) begin
                m_lat = lat_of(ex_mc_type);
                m_pos = 2;
            end
        end else if (m_pos < m_lat) begin
            m_pos++;
        end else begin
            m_pos = 0;
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        id_valid = v.id_valid;   id_rs = v.id_rs;     id_rt = v.id_rt;
        id_uses_rt = v.id_uses_rt; ex_rs = v.ex_rs;   ex_rt = v.ex_rt;
        ex_rw = v.ex_rw;         ex_regwr = v.ex_regwr; ex_load = v.ex_load;
        ex_start_mc = v.ex_start_mc; ex_mc_type = v.ex_mc_type;
        mem_rw = v.mem_rw;       mem_regwr = v.mem_regwr;
        wb_rw = v.wb_rw;         wb_regwr = v.wb_regwr; redirect = v.redirect;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick(input string name, input bit has_exp, input logic [11:0] exp);
        @(negedge clk);
        check({name, "/model"}, dut_out, model_out());
        if (has_exp) check(name, dut_out, exp);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic add(input in_t v, input logic [11:0] e, input string n);
        vec_t r;
        r.in = v; r.exp = e; r.name = n;
        tbl.push_back(r);
    endtask

    task automatic run_mc(input logic [1:0] t, input int lat, input string n);
        in_t v;
        v = '0;
        v.ex_start_mc = 1'b1;
        v.ex_mc_type  = t;
        drive(v);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k == 2) begin
                v.ex_start_mc = 1'b0;
                drive(v);
            end
            if (k < lat)       tick($sformatf("%s_c%0d", n, k), 1'b1, O_BUSY);
            else if (k == lat) tick($sformatf("%s_done", n), 1'b1, O_DONE);
            else               tick($sformatf("%s_idle", n), 1'b1, 12'd0);
        end
    endtask

    initial begin
        in_t v;

        // Reset held with start and redirect asserted.
        v = '0;
        v.ex_start_mc = 1'b1;
        v.redirect    = 1'b1;
        drive(v);
        rst_n = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        tick("rst_c1", 1'b1, 12'd0);
        tick("rst_c2", 1'b1, 12'd0);
        rst_n = 1'b1;
        v = '0;
        drive(v);
        tick("rst_release", 1'b1, 12'd0);

        // Single-cycle vectors, all applied with no op in flight.
        v = '0; v.ex_rs = 3; v.ex_rt = 3; v.mem_rw = 3; v.mem_regwr = 1; v.wb_rw = 3; v.wb_regwr = 1;
        add(v, 12'b0000_0010_1000, "fwd_mem");
        v.mem_regwr = 0;
        add(v, 12'b0000_0001_0100, "fwd_wb");
        v.mem_regwr = 1; v.ex_rs = 0; v.ex_rt = 0; v.mem_rw = 0; v.wb_rw = 0;
        add(v, 12'b0000_0000_0000, "fwd_r0");
        v = '0; v.ex_rs = 3; v.ex_rt = 4; v.mem_rw = 3; v.mem_regwr = 1; v.wb_rw = 4; v.wb_regwr = 1;
        add(v, 12'b0000_0010_0100, "fwd_split");
        v = '0; v.ex_load = 1; v.ex_regwr = 1; v.ex_rw = 5; v.id_rs = 5; v.id_valid = 1;
        add(v, 12'b1101_0000_0000, "lu_rs");
        v.id_rs = 0; v.id_rt = 5; v.id_uses_rt = 0;
        add(v, 12'b0000_0000_0000, "lu_rt_unused");
        v.id_uses_rt = 1;
        add(v, 12'b1101_0000_0000, "lu_rt");
        v.ex_rw = 0; v.id_rt = 0;
        add(v, 12'b0000_0000_0000, "lu_r0");
        v.ex_rw = 5; v.id_rt = 5; v.id_valid = 0;
        add(v, 12'b0000_0000_0000, "lu_invalid");
        v = '0; v.redirect = 1; v.ex_start_mc = 1; v.ex_mc_type = 2'b01;
        add(v, 12'b0011_0100_0000, "redir_start");
        v = '0; v.redirect = 1; v.ex_load = 1; v.ex_regwr = 1; v.ex_rw = 5; v.id_rs = 5; v.id_valid = 1;
        add(v, 12'b0011_0000_0000, "redir_lu");
        v = '0; v.redirect = 1;
        add(v, 12'b0011_0000_0000, "redir");

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            tick(tbl[i].name, 1'b1, tbl[i].exp);
        end

        // Load-use stalls once; next cycle the load sits in MEM and is forwarded.
        v = '0; v.ex_load = 1; v.ex_regwr = 1; v.ex_rw = 5; v.id_rs = 5; v.id_valid = 1;
        drive(v);
        tick("lu_seq_stall", 1'b1, 12'b1101_0000_0000);
        v = '0; v.ex_rs = 5; v.mem_rw = 5; v.mem_regwr = 1; v.id_valid = 1;
        drive(v);
        tick("lu_seq_release", 1'b1, 12'b0000_0010_0000);

        run_mc(2'b01, DIV_LAT, "div");
        run_mc(2'b10, FP_LAT, "fp");
        run_mc(2'b00, MUL_LAT, "mul");
        run_mc(2'b11, MUL_LAT, "rsv");

        // Start held high: DONE must return to IDLE before the next start.
        v = '0; v.ex_start_mc = 1; v.ex_mc_type = 2'b00;
        drive(v);
        for (int k = 1; k <= MUL_LAT; k++) tick("b2b_first", 1'b1, (k < MUL_LAT) ? O_BUSY : O_DONE);
        tick("b2b_restart", 1'b1, O_BUSY);
        v.ex_start_mc = 0;
        drive(v);
        for (int k = 2; k <= MUL_LAT; k++) tick("b2b_second", 1'b1, (k < MUL_LAT) ? O_BUSY : O_DONE);
        tick("b2b_idle", 1'b1, 12'd0);

        // Reset on cycle 3 of a divide abandons it without a done pulse.
        v = '0; v.ex_start_mc = 1; v.ex_mc_type = 2'b01;
        drive(v);
        tick("mid_rst_c1", 1'b1, O_BUSY);
        v.ex_start_mc = 0;
        drive(v);
        tick("mid_rst_c2", 1'b1, O_BUSY);
        rst_n = 1'b0;
        tick("mid_rst_c3", 1'b1, O_BUSY);
        rst_n = 1'b1;
        tick("mid_rst_after", 1'b1, 12'd0);
        for (int k = 0; k < DIV_LAT + 2; k++) tick("mid_rst_quiet", 1'b1, 12'd0);

        // Random traffic with occasional resets, against the model only.
        for (int k = 0; k < 3000; k++) begin
            v.id_valid    = $urandom_range(0, 3) != 0;
            v.id_rs       = 5'($urandom_range(0, 3));
            v.id_rt       = 5'($urandom_range(0, 3));
            v.id_uses_rt  = 1'($urandom_range(0, 1));
            v.ex_rs       = 5'($urandom_range(0, 3));
            v.ex_rt       = 5'($urandom_range(0, 3));
            v.ex_rw       = 5'($urandom_range(0, 3));
            v.ex_regwr    = 1'($urandom_range(0, 1));
            v.ex_load     = 1'($urandom_range(0, 1));
            v.ex_start_mc = $urandom_range(0, 7) == 0;
            v.ex_mc_type  = 2'($urandom_range(0, 3));
            v.mem_rw      = 5'($urandom_range(0, 3));
            v.mem_regwr   = 1'($urandom_range(0, 1));
            v.wb_rw       = 5'($urandom_range(0, 3));
            v.wb_regwr    = 1'($urandom_range(0, 1));
            v.redirect    = $urandom_range(0, 7) == 0;
            drive(v);
            rst_n = $urandom_range(0, 99) != 0;
            tick("rand", 1'b0, 12'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
